// File: rtl/ram_reader.sv
// Frame read sequencer: streams NUMADDR words from a 1-cycle-latency RAM, linear or bit-reversed,
// through a 2-entry skid FIFO onto a valid/ready stream with a last-word flag.
module ram_reader #(
  parameter int unsigned WORDSIZE = 16,
  parameter int unsigned ADDRSIZE = 8,
  parameter int unsigned NUMADDR  = 64,
  parameter bit          BITREV   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [ADDRSIZE-1:0] ram_read_addr,
  output logic                ram_rd_en,
  output logic                ram_wr_en,
  output logic                ram_cs,
  input  logic [WORDSIZE-1:0] ram_data_out,
  output logic [WORDSIZE-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last
);
  localparam int unsigned AddrW = $clog2(NUMADDR);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(NUMADDR - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e              r_state, w_state_d;
  logic [CntW-1:0]     r_addr_cnt, w_addr_cnt_d;
  logic [CntW-1:0]     r_out_cnt, w_out_cnt_d;
  logic                r_inflight;
  logic                r_done, w_done_d;
  logic [WORDSIZE-1:0] r_mem [2];
  logic                r_wr_ptr, r_rd_ptr;
  logic [1:0]          r_count, w_count_d;
  logic [1:0]          w_occ;
  logic                w_push, w_pop;
  logic [ADDRSIZE-1:0] w_map;

  assign w_push    = r_inflight;
  assign m_valid   = (r_count != 2'd0);
  assign w_pop     = m_valid & m_ready;
  assign m_data    = m_valid ? r_mem[r_rd_ptr] : '0;
  assign m_last    = m_valid & (r_out_cnt == LastIdx);
  assign busy      = (r_state != StIdle);
  assign ram_cs    = busy;
  assign done      = r_done;
  assign ram_wr_en = 1'b0;

  // Occupancy after this cycle's pop; a read may only be issued if its word will have a slot.
  assign w_occ     = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
  assign ram_rd_en = (r_state == StRead) && (w_occ < 2'd2);

  always_comb begin
    w_map = '0;
    for (int i = 0; i < int'(AddrW); i++) begin
      w_map[i] = BITREV ? r_addr_cnt[int'(AddrW) - 1 - i] : r_addr_cnt[i];
    end
  end
  assign ram_read_addr = ram_rd_en ? w_map : '0;

  always_comb begin
    w_state_d    = r_state;
    w_addr_cnt_d = r_addr_cnt;
    w_out_cnt_d  = r_out_cnt;
    w_done_d     = 1'b0;
    w_count_d    = r_count + {1'b0, w_push} - {1'b0, w_pop};
    unique case (r_state)
      StIdle: begin
        // r_done high means this is the done cycle, where a new start is refused.
        if (start && !r_done) begin
          w_state_d    = StRead;
          w_addr_cnt_d = '0;
          w_out_cnt_d  = '0;
        end
      end
      StRead: begin
        if (ram_rd_en) begin
          w_addr_cnt_d = r_addr_cnt + CntW'(1);
          if (r_addr_cnt == LastIdx) w_state_d = StDrain;
        end
      end
      StDrain: begin
        if (w_pop && (r_out_cnt == LastIdx)) begin
          w_state_d = StIdle;
          w_done_d  = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_pop) w_out_cnt_d = r_out_cnt + CntW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_addr_cnt <= '0;
      r_out_cnt  <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
    end else begin
      r_state    <= w_state_d;
      r_addr_cnt <= w_addr_cnt_d;
      r_out_cnt  <= w_out_cnt_d;
      r_inflight <= ram_rd_en;
      r_done     <= w_done_d;
      r_count    <= w_count_d;
      if (w_push) begin
        r_mem[r_wr_ptr] <= ram_data_out;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
    end
  end

  a_no_full_push: assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_count == 2'd2)));

endmodule
